mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single off-chip memory port between I-cache refill (i_*) and D-cache refill/writeback (d_*).
//  Drives mem_stall_o, which freezes the PC and pipeline registers while any cache miss is outstanding.
//  Sits between the two cache controllers and the data-memory model; owns the whole memory handshake.
// PARAMETERS
//  ADDR_W   32   byte-address width of all address ports
//  LINE_W   256  cache-line width in bits; every transfer moves one full line
// PORTS
//  clk_i        in   1        clock; all state changes on posedge
//  rst_i        in   1        asynchronous reset, active-high
//  i_req_i      in   1        I-cache line-read request; level, held until i_ack_o
//  i_addr_i     in   ADDR_W   I-cache line address, stable while i_req_i
//  i_ack_o      out  1        one-cycle pulse; i_rdata_o valid in the same cycle
//  i_rdata_o    out  LINE_W   returned I-line
//  d_req_i      in   1        D-cache request; level, held until d_ack_o
//  d_we_i       in   1        1 = line write (writeback), 0 = line read
//  d_addr_i     in   ADDR_W   D-cache line address
//  d_wdata_i    in   LINE_W   writeback data
//  d_ack_o      out  1        one-cycle pulse; d_rdata_o valid on reads
//  d_rdata_o    out  LINE_W   returned D-line
//  mem_req_o    out  1        memory request; held until mem_ack_i is sampled high
//  mem_we_o     out  1        write strobe qualifying mem_req_o
//  mem_addr_o   out  ADDR_W   memory address
//  mem_wdata_o  out  LINE_W   memory write data
//  mem_ack_i    in   1        memory completion; valid only while mem_req_o=1
//  mem_rdata_i  in   LINE_W   memory read data, valid with mem_ack_i
//  mem_stall_o  out  1        (i_req_i&~i_ack_o)|(d_req_i&~d_ack_o); combinational
// BEHAVIOUR
//  Reset: state=IDLE; all *_ack_o, mem_req_o, mem_we_o = 0; all addr/data outputs = 0.
//  FSM: IDLE -> BUSY_D | BUSY_I -> RESP -> IDLE.
//   IDLE: if d_req_i, latch d_addr/we/wdata into the mem_* regs and go to BUSY_D; else if i_req_i, do the same for I and go to BUSY_I.
//   Fixed priority D over I: the D miss belongs to the older instruction. Both requests in the same cycle -> D granted first.
//   BUSY_x: mem_req_o=1, mem_* outputs stable. On mem_ack_i=1: capture mem_rdata_i, drop mem_req_o, go to RESP.
//   RESP: pulse x_ack_o for exactly 1 cycle with the captured data, then go to IDLE. A new request can be granted the next cycle.
//  Latency: request seen in cycle 0 -> mem_req_o in cycle 1 -> ack in cycle N (N>=1) -> x_ack_o in cycle N+1. Minimum 3 cycles.
//  The requester drops x_req_i in the cycle after x_ack_o. A request still high in IDLE with ack just done is not re-granted in the same cycle.
//  A requester deasserting x_req_i before its ack is illegal; the transfer still completes and the ack is still pulsed.
//  mem_ack_i while mem_req_o=0 is ignored.
//  rst_i mid-transfer: immediate return to IDLE, outputs at reset values; an in-flight memory op is abandoned.
//  Writes: d_rdata_o is held at its previous value and not updated.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds output stall_cnt_o [31:0].
//   Reset value 0; +1 on every cycle with mem_stall_o=1; wraps at 2^32-1 -> 0.
//   Adds output grant_cnt_o [15:0]: +1 per x_ack_o pulse, wraps.
//  MEM_ARB_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  Shared package: state encoding localparams (ST_IDLE, ST_BUSY_I, ST_BUSY_D, ST_RESP), plus the LINE_W and ADDR_W defaults.
//  One natural sub-module: mem_arb_perf_cnt (the counters), instantiated only under MEM_ARB_PERF_EN.
//  Grant, FSM and data capture remain in this module.
// TESTING
//  I-only read at 0x0000_0040, memory ack 4 cycles after mem_req_o -> mem_addr_o=0x40, i_ack_o at cycle 6, mem_stall_o=1 for cycles 0-5.
//  i_req_i and d_req_i raised the same cycle (D read 0x100) -> D granted first, d_ack_o pulses, then I granted; stall holds until i_ack_o.
//  D write 0x200 with wdata=0xA5.. -> mem_we_o=1 and mem_wdata_o match; d_rdata_o unchanged; d_ack_o is 1 cycle wide.
//  rst_i pulsed during BUSY_I -> mem_req_o=0 asynchronously, state IDLE; a re-raised request restarts cleanly.
//  Spurious mem_ack_i in IDLE -> no ack and no state change.
//  With MEM_ARB_PERF_EN: the two-request scenario gives stall_cnt_o equal to the number of stall cycles and grant_cnt_o=2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encoding and width defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// rtl/mem_arb_perf_cnt.sv - stall-cycle and grant counters, built only with MEM_ARB_PERF_EN
`ifdef MEM_ARB_PERF_EN
module mem_arb_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        grant_i,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] grant_cnt_o
);

  // Both counters wrap naturally at their width.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      grant_cnt_o <= '0;
    end else begin
      if (stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (grant_i) grant_cnt_o <= grant_cnt_o + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the memory port between I- and D-cache refills, D first
// MEM_ARB_PERF_EN adds stall_cnt_o / grant_cnt_o via mem_arb_perf_cnt.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [LINE_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              mem_stall_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [15:0]       grant_cnt_o
`endif
);

  arb_state_t state_q, state_d;
  logic       owner_d_q;
  logic       we_q;
  logic       grant_d, grant_i, capture;

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The D miss belongs to the older instruction, so it wins ties.
        if (d_req_i) begin
          grant_d = 1'b1;
          state_d = ST_BUSY_D;
        end else if (i_req_i) begin
          grant_i = 1'b1;
          state_d = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ack_i) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_rdata_o   <= '0;
      d_rdata_o   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_d_q   <= 1'b1;
        we_q        <= d_we_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else if (grant_i) begin
        owner_d_q   <= 1'b0;
        we_q        <= 1'b0;
        mem_addr_o  <= i_addr_i;
        mem_wdata_o <= '0;
      end
      // A writeback leaves the last D read line untouched.
      if (capture) begin
        if (!owner_d_q) i_rdata_o <= mem_rdata_i;
        else if (!we_q) d_rdata_o <= mem_rdata_i;
      end
    end
  end

  assign mem_req_o   = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
  assign mem_we_o    = mem_req_o & we_q;
  assign i_ack_o     = (state_q == ST_RESP) & ~owner_d_q;
  assign d_ack_o     = (state_q == ST_RESP) & owner_d_q;
  assign mem_stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .stall_i     (mem_stall_o),
    .grant_i     (i_ack_o | d_ack_o),
    .stall_cnt_o (stall_cnt_o),
    .grant_cnt_o (grant_cnt_o)
  );
`endif

endmodule
